// File: rtl/hid_report_hub_if.sv
// Bundle of the HID report hub's report inputs, control pulses and byte-stream port.
// The producer/consumer side uses master; the hub itself uses slave.
interface hid_report_hub_if #(
  parameter int C_channels     = 2,
  parameter int C_report_bytes = 8
);
  logic [C_channels*C_report_bytes*8-1:0] hid_report;
  logic [C_channels-1:0]                  hid_valid;
  logic                                   freeze;
  logic                                   clr_overrun;
  logic [C_channels*C_report_bytes*8-1:0] display;
  logic [C_channels*8-1:0]                report_count;
  logic [C_channels-1:0]                  overrun;
  logic [7:0]                             out_data;
  logic                                   out_valid;
  logic                                   out_ready;

  modport master (
    output hid_report, hid_valid, freeze, clr_overrun, out_ready,
    input  display, report_count, overrun, out_data, out_valid
  );

  modport slave (
    input  hid_report, hid_valid, freeze, clr_overrun, out_ready,
    output display, report_count, overrun, out_data, out_valid
  );
endinterface

// File: rtl/hid_report_hub.sv
// Latches per-channel HID reports and serialises changed ones as framed byte
// bursts (header 0xA<ch>, then report bytes LSB first), served round-robin.
module hid_report_hub #(
  parameter int C_channels     = 2,
  parameter int C_report_bytes = 8,
  parameter int C_on_change    = 1
) (
  input logic             clk,
  input logic             rst,
  hid_report_hub_if.slave bus
);
  localparam int CH_W  = (C_channels > 1) ? $clog2(C_channels) : 1;
  localparam int IDX_W = (C_report_bytes > 1) ? $clog2(C_report_bytes) : 1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(C_channels - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_report_bytes - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  typedef logic [C_report_bytes-1:0][7:0] report_t;

  report_t [C_channels-1:0]   rep_in;
  report_t [C_channels-1:0]   display_q, display_d;
  logic [C_channels-1:0][7:0] count_q, count_d;
  logic [C_channels-1:0]      pending_q, pending_d;
  logic [C_channels-1:0]      overrun_q, overrun_d;
  logic [C_channels-1:0]      accept, set_pend, serve;
  report_t                    shadow_q, shadow_d;
  logic [1:0]                 state_q, state_d;
  logic [CH_W-1:0]            last_q, last_d;
  logic [CH_W-1:0]            sel_ch, cand;
  logic                       sel_found;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [3:0]                 hdr_ch;

  assign rep_in = bus.hid_report;
  assign accept = bus.hid_valid & {C_channels{~bus.freeze}};

  // Round-robin search: scan downwards so the nearest channel after last_q wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    sel_ch    = last_q;
    sel_found = 1'b0;
    cand      = '0;
    for (int i = C_channels; i >= 1; i--) begin
      cand = CH_W'((int'(last_q) + i) % C_channels);
      if (pending_q[cand]) begin
        sel_ch    = cand;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    serve    = '0;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          serve[sel_ch] = 1'b1;
          shadow_d      = display_q[sel_ch];
          last_d        = sel_ch;
          state_d       = S_HDR;
        end
      end
      S_HDR: begin
        if (bus.out_ready) begin
          idx_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.out_ready) begin
          if (idx_q == LAST_IDX) state_d = S_IDLE;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    display_d = display_q;
    count_d   = count_q;
    set_pend  = '0;
    for (int n = 0; n < C_channels; n++) begin
      set_pend[n] = accept[n] && ((C_on_change == 0) || (rep_in[n] != display_q[n]));
      if (accept[n]) begin
        display_d[n] = rep_in[n];
        count_d[n]   = count_q[n] + 8'd1;
      end
    end
    // A report landing while its channel is being served is not a loss: the
    // old copy is already in the shadow buffer, so only an unserved one overruns.
    pending_d = (pending_q & ~serve) | set_pend;
    overrun_d = (overrun_q & ~{C_channels{bus.clr_overrun}})
              | (set_pend & pending_q & ~serve);
  end

  always_comb begin
    hdr_ch             = '0;
    hdr_ch[CH_W-1:0]   = last_q;
    case (state_q)
      S_HDR:   bus.out_data = {4'hA, hdr_ch};
      S_DATA:  bus.out_data = shadow_q[idx_q];
      default: bus.out_data = 8'h00;
    endcase
  end

  assign bus.out_valid    = (state_q != S_IDLE);
  assign bus.display      = display_q;
  assign bus.report_count = count_q;
  assign bus.overrun      = overrun_q;

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the report stores are reset because display is architecturally
      // visible and change detection compares against it.
      display_q <= '0;
      shadow_q  <= '0;
      count_q   <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      state_q   <= S_IDLE;
      last_q    <= LAST_CH;
      idx_q     <= '0;
    end else begin
      display_q <= display_d;
      shadow_q  <= shadow_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      state_q   <= state_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
    end
  end
endmodule
